// File: rtl/glb_rd_reader.sv
// GLB read-port client: fetches wide beats and serializes the ParBank valid lanes into a narrow stream.
// Define GLB_RD_PREFETCH_EN to add a ping-pong beat register so the next fetch overlaps draining.
module glb_rd_reader #(
    parameter int SRAM_WIDTH = 256,
    parameter int MAXPAR     = 32,
    parameter int ADDR_WIDTH = 16,
    localparam int PW        = $clog2(MAXPAR) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         CfgVld,
    output logic                         CfgRdy,
    input  logic [PW-1:0]                CfgParBank,
    input  logic [ADDR_WIDTH-1:0]        CfgNumBeat,
    output logic                         PortRst,
    input  logic [SRAM_WIDTH*MAXPAR-1:0] RdPortDat,
    input  logic                         RdPortDatVld,
    output logic                         RdPortDatRdy,
    output logic [SRAM_WIDTH-1:0]        OutDat,
    output logic                         OutDatVld,
    output logic                         OutDatLast,
    input  logic                         OutDatRdy,
    output logic                         Fnh
);

    localparam int LW = (MAXPAR > 1) ? $clog2(MAXPAR) : 1;
    localparam int DW = SRAM_WIDTH * MAXPAR;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    started_q;
    logic                    port_rst_q;
    logic [PW-1:0]           par_bank_q, par_bank_d;
    logic [PW-1:0]           lane_idx_q, lane_idx_d;
    logic [PW-1:0]           cfg_par_clamped;
    logic [ADDR_WIDTH-1:0]   num_beat_q, num_beat_d;
    logic [ADDR_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic                    cfg_acc, glb_hs, out_hs;
    logic                    lane_last, beat_last, next_avail;
    logic [DW-1:0]           cur_beat;
    logic [SRAM_WIDTH-1:0]   lanes [MAXPAR];

`ifdef GLB_RD_PREFETCH_EN
    logic [DW-1:0]           hold_q [2];
    logic                    cur_sel_q, cur_sel_d;
    logic                    spare_vld_q, spare_vld_d;
    logic [ADDR_WIDTH-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic                    wr_sel;

    // In LOAD both slots are empty, so the fetched beat becomes the current one.
    assign wr_sel       = (state_q == S_LOAD) ? cur_sel_q : ~cur_sel_q;
    assign cur_beat     = hold_q[cur_sel_q];
    assign next_avail   = spare_vld_q | glb_hs;
    assign RdPortDatRdy = (state_q == S_LOAD) |
                          ((state_q == S_DRAIN) & ~spare_vld_q & (fetch_cnt_q < num_beat_q));

    always_ff @(posedge clk) begin
        if (glb_hs) begin
            hold_q[wr_sel] <= RdPortDat;
        end
    end
`else
    logic [DW-1:0]           hold_q;

    assign cur_beat     = hold_q;
    assign next_avail   = 1'b0;
    assign RdPortDatRdy = (state_q == S_LOAD);

    always_ff @(posedge clk) begin
        if (glb_hs) begin
            hold_q <= RdPortDat;
        end
    end
`endif

    for (genvar gi = 0; gi < MAXPAR; gi++) begin : g_lane
        assign lanes[gi] = cur_beat[gi*SRAM_WIDTH +: SRAM_WIDTH];
    end

    assign CfgRdy     = started_q & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign OutDatVld  = (state_q == S_DRAIN);
    assign OutDat     = OutDatVld ? lanes[lane_idx_q[LW-1:0]] : '0;
    assign OutDatLast = OutDatVld & lane_last & beat_last;
    assign Fnh        = (state_q == S_DONE);
    assign PortRst    = port_rst_q;

    assign cfg_acc   = CfgVld & CfgRdy;
    assign glb_hs    = RdPortDatVld & RdPortDatRdy;
    assign out_hs    = OutDatVld & OutDatRdy;
    assign lane_last = (lane_idx_q == par_bank_q - PW'(1));
    assign beat_last = (beat_cnt_q == num_beat_q - ADDR_WIDTH'(1));

    always_comb begin
        cfg_par_clamped = CfgParBank;
        if (CfgParBank == '0) begin
            cfg_par_clamped = PW'(1);
        end else if (CfgParBank > PW'(MAXPAR)) begin
            cfg_par_clamped = PW'(MAXPAR);
        end
    end

    always_comb begin
        state_d    = state_q;
        par_bank_d = par_bank_q;
        num_beat_d = num_beat_q;
        beat_cnt_d = beat_cnt_q;
        lane_idx_d = lane_idx_q;
`ifdef GLB_RD_PREFETCH_EN
        cur_sel_d   = cur_sel_q;
        spare_vld_d = spare_vld_q;
        fetch_cnt_d = fetch_cnt_q;
        if (glb_hs) begin
            fetch_cnt_d = fetch_cnt_q + ADDR_WIDTH'(1);
            if (state_q == S_DRAIN) begin
                spare_vld_d = 1'b1;
            end
        end
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_acc) begin
                    par_bank_d = cfg_par_clamped;
                    num_beat_d = CfgNumBeat;
                    beat_cnt_d = '0;
                    lane_idx_d = '0;
                    state_d    = (CfgNumBeat == '0) ? S_DONE : S_LOAD;
`ifdef GLB_RD_PREFETCH_EN
                    fetch_cnt_d = '0;
                    spare_vld_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (glb_hs) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    if (lane_last) begin
                        lane_idx_d = '0;
                        beat_cnt_d = beat_cnt_q + ADDR_WIDTH'(1);
                        if (beat_last) begin
                            state_d = S_DONE;
                        end else if (next_avail) begin
                            // A beat arriving this very cycle lands in the slot we switch to.
                            state_d = S_DRAIN;
`ifdef GLB_RD_PREFETCH_EN
                            cur_sel_d   = ~cur_sel_q;
                            spare_vld_d = 1'b0;
`endif
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        lane_idx_d = lane_idx_q + PW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            started_q  <= 1'b0;
            port_rst_q <= 1'b0;
            par_bank_q <= '0;
            num_beat_q <= '0;
            beat_cnt_q <= '0;
            lane_idx_q <= '0;
`ifdef GLB_RD_PREFETCH_EN
            cur_sel_q   <= 1'b0;
            spare_vld_q <= 1'b0;
            fetch_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            port_rst_q <= cfg_acc;
            par_bank_q <= par_bank_d;
            num_beat_q <= num_beat_d;
            beat_cnt_q <= beat_cnt_d;
            lane_idx_q <= lane_idx_d;
`ifdef GLB_RD_PREFETCH_EN
            cur_sel_q   <= cur_sel_d;
            spare_vld_q <= spare_vld_d;
            fetch_cnt_q <= fetch_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_glb_rd_reader.sv
// Scoreboard bench for glb_rd_reader: stimulus pushes expected lanes, a negedge monitor pops and compares.
// Build with or without GLB_RD_PREFETCH_EN; only the job-duration expectation differs.
module tb_glb_rd_reader;

    localparam int SW = 256;
    localparam int MP = 32;
    localparam int AW = 16;
    localparam int PW = $clog2(MP) + 1;

`ifdef GLB_RD_PREFETCH_EN
    localparam int JOB_CYCLES = 9;
`else
    localparam int JOB_CYCLES = 10;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              CfgVld;
    logic              CfgRdy;
    logic [PW-1:0]     CfgParBank;
    logic [AW-1:0]     CfgNumBeat;
    logic              PortRst;
    logic [SW*MP-1:0]  RdPortDat;
    logic              RdPortDatVld;
    logic              RdPortDatRdy;
    logic [SW-1:0]     OutDat;
    logic              OutDatVld;
    logic              OutDatLast;
    logic              OutDatRdy;
    logic              Fnh;

    glb_rd_reader #(.SRAM_WIDTH(SW), .MAXPAR(MP), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .CfgVld(CfgVld), .CfgRdy(CfgRdy), .CfgParBank(CfgParBank), .CfgNumBeat(CfgNumBeat),
        .PortRst(PortRst),
        .RdPortDat(RdPortDat), .RdPortDatVld(RdPortDatVld), .RdPortDatRdy(RdPortDatRdy),
        .OutDat(OutDat), .OutDatVld(OutDatVld), .OutDatLast(OutDatLast), .OutDatRdy(OutDatRdy),
        .Fnh(Fnh)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] dat;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_hs = 0;
    int   prst_cnt = 0;
    int   prst_cyc = 0;
    int   last_cyc = 0;
    int   glb_hs_cnt = 0;
    int   glb_beat = 0;
    int   cur_job = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [SW-1:0] lane_val(input int job, input int b, input int l);
        logic [SW-1:0] v;
        v = '0;
        v[7:0]     = l[7:0];
        v[15:8]    = b[7:0];
        v[23:16]   = job[7:0];
        v[SW-1:SW-8] = 8'h5A;
        return v;
    endfunction

    function automatic logic [SW*MP-1:0] mk_beat(input int job, input int b);
        logic [SW*MP-1:0] d;
        for (int l = 0; l < MP; l++) d[l*SW +: SW] = lane_val(job, b, l);
        return d;
    endfunction

    // GLB model: always valid, beat index restarts on every config accept.
    always begin : glb_model
        logic fire;
        @(negedge clk);
        fire = RdPortDatVld && RdPortDatRdy;
        if (CfgVld && CfgRdy) glb_beat = 0;
        @(posedge clk);
        #1;
        if (fire) begin
            glb_beat++;
            glb_hs_cnt++;
        end
        RdPortDat = mk_beat(cur_job, glb_beat);
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold under stall.
    always begin : monitor
        exp_t e;
        logic pv, pr, pl;
        logic [SW-1:0] pd;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (OutDatVld && OutDatRdy) begin
                    n_hs++;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_out: got dat=%h last=%b, expected no output", OutDat, OutDatLast);
                    end else begin
                        e = sb.pop_front();
                        if (OutDat !== e.dat || OutDatLast !== e.last) begin
                            n_err++;
                            $display("FAIL out_lane: got dat=%h last=%b, expected dat=%h last=%b",
                                     OutDat, OutDatLast, e.dat, e.last);
                        end
                    end
                    if (OutDatLast) last_cyc = cyc;
                end
                if (pv && !pr && OutDatVld) begin
                    n_cmp++;
                    if (OutDat !== pd || OutDatLast !== pl) begin
                        n_err++;
                        $display("FAIL stall_hold: got dat=%h last=%b, expected dat=%h last=%b",
                                 OutDat, OutDatLast, pd, pl);
                    end
                end
                if (PortRst) begin
                    prst_cnt++;
                    prst_cyc = cyc;
                end
                pv = OutDatVld; pr = OutDatRdy; pd = OutDat; pl = OutDatLast;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_job(input int job, input int nb, input int lanes);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < lanes; l++) begin
                e.dat  = lane_val(job, b, l);
                e.last = (b == nb - 1) && (l == lanes - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_cfg(input int pb, input int nb, input int job);
        logic ok;
        cur_job    = job;
        CfgParBank = PW'(pb);
        CfgNumBeat = AW'(nb);
        CfgVld     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = CfgRdy;
            tick();
        end
        CfgVld = 1'b0;
        chk("cfg_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_fnh(input string name, output int fcyc);
        for (int i = 0; i < 400; i++) begin
            if (Fnh) break;
            tick();
        end
        chk(name, 64'(Fnh), 64'd1);
        fcyc = cyc;
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 200; i++) begin
            if (n_hs >= target) break;
            tick();
        end
        chk("wait_handshakes", 64'(n_hs), 64'(target));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int fc, p0, h0, base;
        rst = 1'b1; CfgVld = 1'b0; CfgParBank = '0; CfgNumBeat = '0;
        OutDatRdy = 1'b0; RdPortDatVld = 1'b0;
        repeat (3) tick();
        chk("reset_outs", {57'd0, CfgRdy, PortRst, RdPortDatRdy, OutDatVld, OutDatLast, Fnh, |OutDat}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cfgrdy_before_rise", 64'(CfgRdy), 64'd0);
        tick();
        chk("cfgrdy_after_rise", 64'(CfgRdy), 64'd1);

        OutDatRdy = 1'b1;
        RdPortDatVld = 1'b1;

        // NumBeat = 0 from IDLE
        h0 = glb_hs_cnt; p0 = prst_cnt;
        do_cfg(5, 0, 1);
        chk("nb0_portrst_fnh", {62'd0, PortRst, Fnh}, 64'd3);
        repeat (4) tick();
        chk("nb0_no_glb_hs", 64'(glb_hs_cnt - h0), 64'd0);
        chk("nb0_portrst_once", 64'(prst_cnt - p0), 64'd1);

        // Basic job: 4 lanes x 2 beats
        push_job(2, 2, 4);
        p0 = prst_cnt;
        do_cfg(4, 2, 2);
        wait_fnh("basic_fnh", fc);
        chk("basic_fnh_timing", 64'(fc), 64'(last_cyc + 1));
        chk("basic_job_cycles", 64'(last_cyc - prst_cyc + 1), 64'(JOB_CYCLES));
        chk("basic_portrst_once", 64'(prst_cnt - p0), 64'd1);
        chk("basic_sb_empty", 64'(sb.size()), 64'd0);

        // ParBank clamping
        push_job(3, 2, 1);
        do_cfg(0, 2, 3);
        wait_fnh("pb0_fnh", fc);
        chk("pb0_sb_empty", 64'(sb.size()), 64'd0);
        push_job(4, 1, 32);
        do_cfg(40, 1, 4);
        wait_fnh("pb40_fnh", fc);
        chk("pb40_sb_empty", 64'(sb.size()), 64'd0);

        // Consumer stall mid-beat
        push_job(5, 2, 4);
        base = n_hs;
        do_cfg(4, 2, 5);
        wait_hs(base + 2);
        OutDatRdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_vld_rdport", {62'd0, OutDatVld, RdPortDatRdy}, 64'd2);
        end
        tick();
        OutDatRdy = 1'b1;
        wait_fnh("stall_fnh", fc);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Config pulsed during DRAIN is ignored
        push_job(6, 2, 4);
        do_cfg(4, 2, 6);
        for (int i = 0; i < 20 && !OutDatVld; i++) tick();
        CfgVld = 1'b1; CfgParBank = PW'(1); CfgNumBeat = AW'(5);
        @(negedge clk);
        chk("cfgrdy_busy", 64'(CfgRdy), 64'd0);
        tick();
        CfgVld = 1'b0;
        wait_fnh("ignore_cfg_fnh", fc);
        chk("ignore_cfg_sb_empty", 64'(sb.size()), 64'd0);

        // Config in DONE starts a new job and drops Fnh
        push_job(7, 1, 2);
        do_cfg(2, 1, 7);
        chk("fnh_drop", {62'd0, Fnh, PortRst}, 64'd1);
        wait_fnh("done_cfg_fnh", fc);
        chk("done_cfg_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during DRAIN of beat 1 of 3, then replay
        push_job(8, 3, 4);
        base = n_hs;
        do_cfg(4, 3, 8);
        wait_hs(base + 5);
        OutDatRdy = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_outs", {57'd0, CfgRdy, PortRst, RdPortDatRdy, OutDatVld, OutDatLast, Fnh, |OutDat}, 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (2) tick();
        OutDatRdy = 1'b1;
        push_job(9, 3, 4);
        do_cfg(4, 3, 9);
        wait_fnh("replay_fnh", fc);
        chk("replay_sb_empty", 64'(sb.size()), 64'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
